// File: rtl/stream_output_arbiter_pkg.sv
// Shared definitions for the stream output arbiter: FSM state encoding,
// default message terminator and width helpers for counters and indices.
package stream_output_arbiter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  // Newline: the usual end-of-message marker for text producers.
  localparam logic [31:0] DEFAULT_TERMINATOR = 32'h0000_000A;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Bits needed to hold 0 .. value-1, never less than one bit so that
  // degenerate parameter values still produce legal vectors.
  function automatic int min_width(input int value);
    int w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_output_arbiter_rr_priority_select.sv
// Round-robin priority selector: given the request vector and the last
// granted index, returns the first requester found searching last+1,
// last+2, ... (mod N), plus a flag saying whether anyone is requesting.
module stream_output_arbiter_rr_priority_select #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_grant_i,
  output logic [GW-1:0] next_id_o,
  output logic          any_o
);

  logic          hi_any;
  logic [GW-1:0] hi_id;
  logic [GW-1:0] lo_id;

  // Scan downwards so the last hit is the lowest index: hi_id is the lowest
  // requester above last_grant, lo_id the lowest requester overall (wrap).
  always_comb begin
    hi_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_id = GW'(j);
        if (j > int'(last_grant_i)) begin
          hi_any = 1'b1;
          hi_id  = GW'(j);
        end
      end
    end
    any_o     = |req_i;
    next_id_o = hi_any ? hi_id : lo_id;
  end

endmodule

// File: rtl/stream_output_arbiter.sv
// Shares one stb/ack output stream between N_INPUTS producers. Grants are
// round-robin and message-locked: the owner keeps the output until it sends
// TERMINATOR, reaches MAX_BURST words, or leaves stb low for IDLE_TIMEOUT
// cycles. Data, strobe and ack are passed straight through while granted.
//
// Handshake: a word transfers on a stream in any cycle where that stream's
// stb and ack are both high; producers hold data and stb stable until acked,
// and ack may be given only while the matching stb is observed.
module stream_output_arbiter
  import stream_output_arbiter_pkg::*;
#(
  parameter int               N_INPUTS     = 4,
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TERMINATOR   = WIDTH'(DEFAULT_TERMINATOR),
  parameter int               MAX_BURST    = 64,
  parameter int               IDLE_TIMEOUT = 1024,
  localparam int              GW           = min_width(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_stb,
  output logic [N_INPUTS-1:0]       in_ack,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_stb,
  input  logic                      out_ack,
  output logic                      grant_valid,
  output logic [GW-1:0]             grant_id,
  output logic                      timeout_pulse,
  output state_e                    dbg_state
);

  localparam int            BW         = min_width(MAX_BURST);
  localparam int            TW         = min_width(IDLE_TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_INIT  = GW'(N_INPUTS - 1);

  state_e          state_q;
  logic [GW-1:0]   grant_id_q;
  logic [GW-1:0]   last_grant_q;
  logic [BW-1:0]   burst_cnt_q;
  logic [BW-1:0]   burst_cnt_d;
  logic [TW-1:0]   idle_cnt_q;
  logic [TW-1:0]   idle_cnt_d;
  logic            timeout_q;

  logic [GW-1:0]   sel_id;
  logic            sel_any;
  logic [WIDTH-1:0] lane [N_INPUTS];
  logic [WIDTH-1:0] cur_data;
  logic            cur_stb;
  logic            xfer;
  logic            word_release_d;
  logic            timeout_release_d;
  logic            release_d;

  // Split the flat producer bus into one lane per input.
  for (genvar g = 0; g < N_INPUTS; g++) begin : g_lane
    assign lane[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign cur_data = lane[grant_id_q];
  assign cur_stb  = in_stb[grant_id_q];

  stream_output_arbiter_rr_priority_select #(
    .N  (N_INPUTS),
    .GW (GW)
  ) u_rr_select (
    .req_i        (in_stb),
    .last_grant_i (last_grant_q),
    .next_id_o    (sel_id),
    .any_o        (sel_any)
  );

  // Output mux: owner's stream straight through; strobe and acks held low in
  // IDLE and while reset is asserted so nothing transfers during reset.
  always_comb begin
    in_ack   = '0;
    out_stb  = 1'b0;
    out_data = '0;
    if (state_q == ST_GRANTED) begin
      out_data = cur_data;
      if (!rst) begin
        out_stb            = cur_stb;
        in_ack[grant_id_q] = out_ack;
      end
    end
  end

  // Release decisions and counter next-state. A transfer resets the stall
  // counter; a low strobe advances it; a held-but-unacked word freezes both.
  always_comb begin
    xfer              = (state_q == ST_GRANTED) && cur_stb && out_ack;
    word_release_d    = xfer && ((cur_data == TERMINATOR) ||
                                 ((MAX_BURST != 0) && (burst_cnt_q == BURST_LAST)));
    timeout_release_d = (state_q == ST_GRANTED) && !cur_stb &&
                        (IDLE_TIMEOUT != 0) && (idle_cnt_q == IDLE_LAST);
    release_d         = word_release_d || timeout_release_d;

    burst_cnt_d = burst_cnt_q;
    if (xfer && (MAX_BURST != 0)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end

    idle_cnt_d = idle_cnt_q;
    if (xfer) begin
      idle_cnt_d = '0;
    end else if ((state_q == ST_GRANTED) && !cur_stb && (IDLE_TIMEOUT != 0)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Grant FSM: IDLE picks the next round-robin requester, GRANTED holds the
  // lock until a terminator, burst limit or stall timeout ends the message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_INIT;
      burst_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_any) begin
            state_q     <= ST_GRANTED;
            grant_id_q  <= sel_id;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
          end
        end
        ST_GRANTED: begin
          if (release_d) begin
            state_q      <= ST_IDLE;
            last_grant_q <= grant_id_q;
            burst_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            timeout_q    <= timeout_release_d;
          end else begin
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_valid   = (state_q == ST_GRANTED);
  assign grant_id      = grant_id_q;
  assign timeout_pulse = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stream_output_arbiter.sv
// Directed bench for stream_output_arbiter with MAX_BURST=4, IDLE_TIMEOUT=8.
// Producers are modelled as per-input word lists; every word expected on the
// shared output is pushed (tagged with its owner id) to a scoreboard queue
// and popped when the output stream transfers.
module tb_stream_output_arbiter;
  import stream_output_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MB  = 4;
  localparam int IT  = 8;
  localparam int SBW = 2 + W;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_stb;
  logic [N-1:0]   in_ack;
  logic [W-1:0]   out_data;
  logic           out_stb;
  logic           out_ack;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           timeout_pulse;
  state_e         dbg_state;

  logic [SBW-1:0] exp_q[$];
  logic [W-1:0]   src_mem [N][16];
  int             src_len [N];
  int             src_pos [N];
  logic           xfer_seen [N];
  int             checks;
  int             errors;
  int             rr_ids [5];

  stream_output_arbiter #(
    .N_INPUTS     (N),
    .WIDTH        (W),
    .TERMINATOR   (32'h0000_000A),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_stb        (in_stb),
    .in_ack        (in_ack),
    .out_data      (out_data),
    .out_stb       (out_stb),
    .out_ack       (out_ack),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse),
    .dbg_state     (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present each producer's current word, or drop its strobe when done.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        in_stb[i]         = 1'b1;
        in_data[i*W +: W] = src_mem[i][src_pos[i]];
      end else begin
        in_stb[i]         = 1'b0;
        in_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic load(input int ch, input logic [W-1:0] w);
    src_mem[ch][src_len[ch]] = w;
    src_len[ch]++;
  endtask

  task automatic expect_word(input int ch, input logic [W-1:0] w);
    exp_q.push_back({2'(ch), w});
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_len[i]   = 0;
      src_pos[i]   = 0;
      xfer_seen[i] = 1'b0;
    end
  endtask

  // One clock: sample handshakes at the falling edge, score output
  // transfers, then advance producers just after the rising edge.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      xfer_seen[i] = in_stb[i] && in_ack[i];
    end
    if (!rst && out_stb && out_ack) begin
      if (exp_q.size() != 0) e = 64'(exp_q.pop_front());
      else                   e = 'x;
      check("sb_word", {30'd0, grant_id, out_data}, e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer_seen[i]) src_pos[i]++;
    end
    drive();
    #1;
  endtask

  task automatic drain(input string tag, input int lim);
    for (int c = 0; c < lim && exp_q.size() != 0; c++) step();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rr_ids  = '{0, 1, 2, 3, 0};
    rst     = 1'b1;
    out_ack = 1'b0;
    in_stb  = '0;
    in_data = '0;
    clear_all();
    repeat (3) step();

    // Reset state
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    check("rst_out_stb", out_stb, 0);
    check("rst_in_ack", in_ack, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    #1;

    // Single requester on input 2, three words back-to-back
    out_ack = 1'b1;
    load(2, 32'h41); load(2, 32'h42); load(2, 32'h0A);
    expect_word(2, 32'h41); expect_word(2, 32'h42); expect_word(2, 32'h0A);
    drive();
    #1;
    check("t1_idle_out_stb", out_stb, 0);
    check("t1_idle_in_ack", in_ack, 0);
    step();
    check("t1_grant_valid", grant_valid, 1);
    check("t1_grant_id", grant_id, 2);
    check("t1_out_stb", out_stb, 1);
    check("t1_word0", out_data, 32'h41);
    check("t1_in_ack", in_ack, 4'b0100);
    step();
    check("t1_word1", out_data, 32'h42);
    step();
    check("t1_word2", out_data, 32'h0A);
    step();
    check("t1_release", grant_valid, 0);
    check("t1_sb_empty", 64'(exp_q.size()), 0);

    // Round robin from reset: all four request, one-word messages
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    clear_all();
    load(0, 32'h0A); load(0, 32'h0A);
    load(1, 32'h0A); load(2, 32'h0A); load(3, 32'h0A);
    for (int k = 0; k < 5; k++) expect_word(rr_ids[k], 32'h0A);
    drive();
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_idle_gap", grant_valid, 0);
      step();
      check("rr_grant_valid", grant_valid, 1);
      check("rr_grant_id", grant_id, 64'(rr_ids[k]));
      step();
    end
    check("rr_done", grant_valid, 0);
    check("rr_sb_empty", 64'(exp_q.size()), 0);

    // Backpressure: consumer withholds ack for five cycles mid-message
    clear_all();
    load(1, 32'h11); load(1, 32'h22); load(1, 32'h0A);
    expect_word(1, 32'h11); expect_word(1, 32'h22); expect_word(1, 32'h0A);
    drive();
    #1;
    step();
    check("bp_grant_id", grant_id, 1);
    step();
    out_ack = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ack_low", in_ack, 0);
      check("bp_data_held", out_data, 32'h22);
      check("bp_stb_held", out_stb, 1);
      step();
    end
    out_ack = 1'b1;
    #1;
    check("bp_in_ack_resume", in_ack, 4'b0010);
    step(); step();
    check("bp_release", grant_valid, 0);
    check("bp_sb_empty", 64'(exp_q.size()), 0);

    // Burst limit: input 1 streams ten plain words while input 3 waits
    clear_all();
    for (int k = 0; k < 10; k++) load(1, 32'h100 + k);
    for (int k = 0; k < 4; k++) expect_word(1, 32'h100 + k);
    drive();
    #1;
    step();
    check("mb_grant_id", grant_id, 1);
    load(3, 32'h0A);
    expect_word(3, 32'h0A);
    for (int k = 4; k < 10; k++) expect_word(1, 32'h100 + k);
    drive();
    #1;
    repeat (4) step();
    check("mb_release_after_4", grant_valid, 0);
    step();
    check("mb_next_grant_valid", grant_valid, 1);
    check("mb_next_grant_id", grant_id, 3);
    drain("mb_drain", 60);
    for (int c = 0; c < 20 && grant_valid; c++) step();
    check("mb_final_release", grant_valid, 0);

    // Stall timeout: owner drops stb after one word
    clear_all();
    load(0, 32'h55);
    expect_word(0, 32'h55);
    drive();
    #1;
    step();
    check("to_grant_id", grant_id, 0);
    step();
    for (int k = 1; k < IT; k++) begin
      step();
      check("to_hold_grant", grant_valid, 1);
      check("to_no_pulse_early", timeout_pulse, 0);
    end
    step();
    check("to_release", grant_valid, 0);
    check("to_pulse", timeout_pulse, 1);
    step();
    check("to_pulse_one_cycle", timeout_pulse, 0);
    check("to_sb_empty", 64'(exp_q.size()), 0);

    // Reset mid-message, then input 0 wins arbitration
    clear_all();
    load(2, 32'h61); load(2, 32'h62); load(2, 32'h0A);
    expect_word(2, 32'h61);
    drive();
    #1;
    step();
    check("mr_grant_id", grant_id, 2);
    step();
    load(0, 32'h0A);
    load(3, 32'h0A);
    drive();
    #1;
    check("mr_pre_data", out_data, 32'h62);
    check("mr_pre_in_ack", in_ack, 4'b0100);
    rst = 1'b1;
    #1;
    check("mr_in_ack_forced", in_ack, 0);
    check("mr_out_stb_forced", out_stb, 0);
    step();
    check("mr_grant_valid", grant_valid, 0);
    check("mr_grant_id_cleared", grant_id, 0);
    src_len[2] = 0;
    src_pos[2] = 0;
    expect_word(0, 32'h0A);
    expect_word(3, 32'h0A);
    rst = 1'b0;
    drive();
    #1;
    step();
    check("mr_input0_wins", grant_id, 0);
    check("mr_regrant_valid", grant_valid, 1);
    drain("mr_drain", 20);
    step();
    check("mr_final_idle", grant_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
